// File: rtl/display_timing_pkg.sv
// ============================================================================
// display_timing_pkg : shared coordinate type, default timing, origin helpers
// Revision: 1.0
// ============================================================================
`default_nettype none

package display_timing_pkg;

  localparam int DEF_COORD_WIDTH = 16;
  localparam int DEF_H_RES       = 320;
  localparam int DEF_H_FP        = 8;
  localparam int DEF_H_SYNC      = 32;
  localparam int DEF_H_BP        = 40;
  localparam int DEF_V_RES       = 240;
  localparam int DEF_V_FP        = 2;
  localparam int DEF_V_SYNC      = 3;
  localparam int DEF_V_BP        = 5;

  typedef logic signed [DEF_COORD_WIDTH-1:0] coord_t;

  // Blanking sits at negative coordinates so active video starts at zero.
  function automatic int calc_h_sta(input int fp, input int sync, input int bp);
    return -(fp + sync + bp);
  endfunction

  function automatic int calc_v_sta(input int fp, input int sync, input int bp);
    return -(fp + sync + bp);
  endfunction

endpackage

`default_nettype wire

// File: rtl/display_timing_if.sv
// ============================================================================
// display_timing_if : video position and sync bundle for downstream stages
// Revision: 1.0
// ============================================================================
`default_nettype none

interface display_timing_if #(
  parameter int COORD_WIDTH = 16
);
  logic signed [COORD_WIDTH-1:0] x;
  logic signed [COORD_WIDTH-1:0] y;
  logic                          hsync;
  logic                          vsync;
  logic                          de;
  logic                          hsync_start;
  logic                          frame_start;
  logic [15:0]                   frame_count;

  modport master (
    output x, y, hsync, vsync, de, hsync_start, frame_start, frame_count
  );

  modport slave (
    input x, y, hsync, vsync, de, hsync_start, frame_start, frame_count
  );
endinterface

`default_nettype wire

// File: rtl/display_timing_counter.sv
// ============================================================================
// timing_counter : signed START..END wrap counter exposing its next value
// Revision: 1.0
// ============================================================================
`default_nettype none

module timing_counter #(
  parameter int WIDTH = 16,
  parameter int START = -80,
  parameter int END   = 319
) (
  input  wire logic                    pixel_clock,
  input  wire logic                    reset,
  input  wire logic                    i_en,
  output logic                         o_wrap,
  output logic signed [WIDTH-1:0]      o_next
);

  localparam logic signed [WIDTH-1:0] C_START = WIDTH'(START);
  localparam logic signed [WIDTH-1:0] C_END   = WIDTH'(END);
  localparam logic signed [WIDTH-1:0] C_ONE   = WIDTH'(1);

  logic signed [WIDTH-1:0] r_count;

  assign o_wrap = i_en && (r_count == C_END);

  always_comb begin
    o_next = r_count;
    if (i_en) begin
      o_next = (r_count == C_END) ? C_START : r_count + C_ONE;
    end
  end

  // Resting at END makes the first edge after reset land on START.
  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) begin
      r_count <= C_END;
    end else begin
      r_count <= o_next;
    end
  end

endmodule

`default_nettype wire

// File: rtl/display_timing.sv
// ============================================================================
// display_timing : signed-coordinate video timing generator with sync strobes
// Optional: DISPLAY_TIMING_FRAME_COUNT_EN enables the 16-bit frame counter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module display_timing
  import display_timing_pkg::*;
#(
  parameter int COORD_WIDTH = DEF_COORD_WIDTH,
  parameter int H_RES       = DEF_H_RES,
  parameter int H_FP        = DEF_H_FP,
  parameter int H_SYNC      = DEF_H_SYNC,
  parameter int H_BP        = DEF_H_BP,
  parameter int V_RES       = DEF_V_RES,
  parameter int V_FP        = DEF_V_FP,
  parameter int V_SYNC      = DEF_V_SYNC,
  parameter int V_BP        = DEF_V_BP,
  parameter int HSYNC_POL   = 1,
  parameter int VSYNC_POL   = 1
) (
  input  wire logic          pixel_clock,
  input  wire logic          reset,
  display_timing_if.master   o_vid
);

  localparam int H_STA = calc_h_sta(H_FP, H_SYNC, H_BP);
  localparam int V_STA = calc_v_sta(V_FP, V_SYNC, V_BP);
  localparam int H_END = H_RES - 1;
  localparam int V_END = V_RES - 1;

  localparam longint C_MIN = -(longint'(1) <<< (COORD_WIDTH - 1));
  localparam longint C_MAX = (longint'(1) <<< (COORD_WIDTH - 1)) - 1;

  localparam logic signed [COORD_WIDTH-1:0] C_H_END  = COORD_WIDTH'(H_END);
  localparam logic signed [COORD_WIDTH-1:0] C_V_END  = COORD_WIDTH'(V_END);
  localparam logic signed [COORD_WIDTH-1:0] C_HS_BEG = COORD_WIDTH'(H_STA + H_FP);
  localparam logic signed [COORD_WIDTH-1:0] C_HS_END = COORD_WIDTH'(H_STA + H_FP + H_SYNC - 1);
  localparam logic signed [COORD_WIDTH-1:0] C_VS_BEG = COORD_WIDTH'(V_STA + V_FP);
  localparam logic signed [COORD_WIDTH-1:0] C_VS_END = COORD_WIDTH'(V_STA + V_FP + V_SYNC - 1);
  localparam logic signed [COORD_WIDTH-1:0] C_ZERO   = '0;
  localparam logic                          C_HS_ON  = (HSYNC_POL != 0);
  localparam logic                          C_VS_ON  = (VSYNC_POL != 0);

  if ((longint'(H_STA) < C_MIN) || (longint'(V_STA) < C_MIN) ||
      (longint'(H_END) > C_MAX) || (longint'(V_END) > C_MAX)) begin : g_err_width
    $error("display_timing: COORD_WIDTH too small for timing range");
  end
  if (H_BP < 8) begin : g_err_hbp
    $error("display_timing: H_BP must be >= 8");
  end
  if ((H_SYNC <= 0) || (V_SYNC <= 0)) begin : g_err_sync
    $error("display_timing: H_SYNC and V_SYNC must be > 0");
  end

  logic                          w_h_wrap;
  logic                          w_v_wrap;
  logic signed [COORD_WIDTH-1:0] w_h_next;
  logic signed [COORD_WIDTH-1:0] w_v_next;

  timing_counter #(
    .WIDTH (COORD_WIDTH),
    .START (H_STA),
    .END   (H_END)
  ) u_h_cnt (
    .pixel_clock (pixel_clock),
    .reset       (reset),
    .i_en        (1'b1),
    .o_wrap      (w_h_wrap),
    .o_next      (w_h_next)
  );

  timing_counter #(
    .WIDTH (COORD_WIDTH),
    .START (V_STA),
    .END   (V_END)
  ) u_v_cnt (
    .pixel_clock (pixel_clock),
    .reset       (reset),
    .i_en        (w_h_wrap),
    .o_wrap      (w_v_wrap),
    .o_next      (w_v_next)
  );

  // Flags decode the next position so every output moves on the same edge.
  logic w_hs_act;
  logic w_vs_act;
  logic w_de;
  logic w_hs_start;
  logic w_fr_start;

  assign w_hs_act   = (w_h_next >= C_HS_BEG) && (w_h_next <= C_HS_END);
  assign w_vs_act   = (w_v_next >= C_VS_BEG) && (w_v_next <= C_VS_END);
  assign w_de       = (w_h_next >= C_ZERO) && (w_v_next >= C_ZERO);
  assign w_hs_start = (w_h_next == C_HS_BEG);
  assign w_fr_start = w_v_wrap;

  logic signed [COORD_WIDTH-1:0] r_x;
  logic signed [COORD_WIDTH-1:0] r_y;
  logic                          r_hsync;
  logic                          r_vsync;
  logic                          r_de;
  logic                          r_hs_start;
  logic                          r_fr_start;

  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) begin
      r_x        <= C_H_END;
      r_y        <= C_V_END;
      r_hsync    <= ~C_HS_ON;
      r_vsync    <= ~C_VS_ON;
      r_de       <= 1'b0;
      r_hs_start <= 1'b0;
      r_fr_start <= 1'b0;
    end else begin
      r_x        <= w_h_next;
      r_y        <= w_v_next;
      r_hsync    <= w_hs_act ? C_HS_ON : ~C_HS_ON;
      r_vsync    <= w_vs_act ? C_VS_ON : ~C_VS_ON;
      r_de       <= w_de;
      r_hs_start <= w_hs_start;
      r_fr_start <= w_fr_start;
    end
  end

`ifdef DISPLAY_TIMING_FRAME_COUNT_EN
  logic [15:0] r_frame_count;

  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) begin
      r_frame_count <= 16'h0000;
    end else if (w_fr_start) begin
      r_frame_count <= r_frame_count + 16'd1;
    end
  end

  assign o_vid.frame_count = r_frame_count;
`else
  assign o_vid.frame_count = 16'h0000;
`endif

  assign o_vid.x           = r_x;
  assign o_vid.y           = r_y;
  assign o_vid.hsync       = r_hsync;
  assign o_vid.vsync       = r_vsync;
  assign o_vid.de          = r_de;
  assign o_vid.hsync_start = r_hs_start;
  assign o_vid.frame_start = r_fr_start;

endmodule

`default_nettype wire

// File: tb/tb_display_timing.sv
// ============================================================================
// tb_display_timing : frame-position model check of display_timing (two configs)
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_display_timing;

  typedef struct {
    int x; int y; int hs; int vs; int de; int hss; int fs; int fc;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_d = 1'b0;
  logic rst_s = 1'b0;
  bit   en    = 1'b0;
  bit   done_s = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   k_d = 0;
  int   k_s = 0;

  always #5 clk = ~clk;

  display_timing_if #(.COORD_WIDTH(16)) vid_d ();
  display_timing_if #(.COORD_WIDTH(8))  vid_s ();

  display_timing #(
    .COORD_WIDTH(16), .H_RES(320), .H_FP(8), .H_SYNC(32), .H_BP(40),
    .V_RES(240), .V_FP(2), .V_SYNC(3), .V_BP(5), .HSYNC_POL(1), .VSYNC_POL(1)
  ) dut_d (.pixel_clock(clk), .reset(rst_d), .o_vid(vid_d));

  display_timing #(
    .COORD_WIDTH(8), .H_RES(16), .H_FP(2), .H_SYNC(4), .H_BP(8),
    .V_RES(6), .V_FP(1), .V_SYNC(2), .V_BP(2), .HSYNC_POL(0), .VSYNC_POL(0)
  ) dut_s (.pixel_clock(clk), .reset(rst_s), .o_vid(vid_s));

  // k = active edges since the last reset release; k == 0 is the reset state.
  always @(posedge clk or posedge rst_d) begin
    if (rst_d) k_d <= 0;
    else       k_d <= k_d + 1;
  end
  always @(posedge clk or posedge rst_s) begin
    if (rst_s) k_s <= 0;
    else       k_s <= k_s + 1;
  end

  function automatic exp_t model(input int k, input int hfp, input int hsy, input int hbp,
                                 input int hres, input int vfp, input int vsy, input int vbp,
                                 input int vres, input int hpol, input int vpol);
    exp_t e;
    int ht, vt, hsta, vsta, p;
    bit hact, vact;
    ht   = hfp + hsy + hbp + hres;
    vt   = vfp + vsy + vbp + vres;
    hsta = -(hfp + hsy + hbp);
    vsta = -(vfp + vsy + vbp);
    if (k == 0) begin
      e.x = hres - 1; e.y = vres - 1; e.hs = 1 - hpol; e.vs = 1 - vpol;
      e.de = 0; e.hss = 0; e.fs = 0; e.fc = 0;
    end else begin
      p    = (k - 1) % (ht * vt);
      e.x  = hsta + p % ht;
      e.y  = vsta + p / ht;
      hact = (e.x >= hsta + hfp) && (e.x < hsta + hfp + hsy);
      vact = (e.y >= vsta + vfp) && (e.y < vsta + vfp + vsy);
      e.hs = hact ? hpol : 1 - hpol;
      e.vs = vact ? vpol : 1 - vpol;
      e.de = (e.x >= 0 && e.y >= 0) ? 1 : 0;
      e.hss = (e.x == hsta + hfp) ? 1 : 0;
      e.fs = (p == 0) ? 1 : 0;
`ifdef DISPLAY_TIMING_FRAME_COUNT_EN
      e.fc = ((k - 1) / (ht * vt) + 1) & 32'hFFFF;
`else
      e.fc = 0;
`endif
    end
    return e;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp(input string tag, input exp_t e, input int x, input int y, input int hs,
                     input int vs, input int de, input int hss, input int fs, input int fc);
    check({tag, ".x"}, x, e.x);
    check({tag, ".y"}, y, e.y);
    check({tag, ".hsync"}, hs, e.hs);
    check({tag, ".vsync"}, vs, e.vs);
    check({tag, ".de"}, de, e.de);
    check({tag, ".hsync_start"}, hss, e.hss);
    check({tag, ".frame_start"}, fs, e.fs);
    check({tag, ".frame_count"}, fc, e.fc);
  endtask

  always @(negedge clk) begin
    if (en) begin
      cmp("def", model(k_d, 8, 32, 40, 320, 2, 3, 5, 240, 1, 1),
          int'($signed(vid_d.x)), int'($signed(vid_d.y)), int'(vid_d.hsync), int'(vid_d.vsync),
          int'(vid_d.de), int'(vid_d.hsync_start), int'(vid_d.frame_start), int'(vid_d.frame_count));
      cmp("small", model(k_s, 2, 4, 8, 16, 1, 2, 2, 6, 0, 0),
          int'($signed(vid_s.x)), int'($signed(vid_s.y)), int'(vid_s.hsync), int'(vid_s.vsync),
          int'(vid_s.de), int'(vid_s.hsync_start), int'(vid_s.frame_start), int'(vid_s.frame_count));
    end
  end

  int hs_cnt = 0, hss_cnt = 0, hss_x = 999, de_cnt = 0;
  int vs_cnt = 0, vs_hss = 0, vs_fx = 999, vs_fy = 999, vs_lx = 999, vs_ly = 999;

  initial begin
    #1 rst_d = 1'b1; rst_s = 1'b1; en = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("held_x", int'($signed(vid_d.x)), 319);
    check("held_y", int'($signed(vid_d.y)), 239);
    check("held_fc", int'(vid_d.frame_count), 0);
    @(negedge clk);
    rst_d = 1'b0; rst_s = 1'b0;
    @(posedge clk); #1;
    check("first_x", int'($signed(vid_d.x)), -80);
    check("first_y", int'($signed(vid_d.y)), -10);
    check("first_fs", int'(vid_d.frame_start), 1);
    check("first_de", int'(vid_d.de), 0);
    check("first_hsync", int'(vid_d.hsync), 0);
    for (int i = 0; i < 4000; i++) begin
      if (i < 400) begin
        if (vid_d.hsync) hs_cnt++;
        if (vid_d.de) de_cnt++;
        if (vid_d.hsync_start) begin hss_cnt++; hss_x = int'($signed(vid_d.x)); end
      end
      if (vid_d.vsync) begin
        if (vs_cnt == 0) begin vs_fx = int'($signed(vid_d.x)); vs_fy = int'($signed(vid_d.y)); end
        vs_lx = int'($signed(vid_d.x)); vs_ly = int'($signed(vid_d.y));
        vs_cnt++;
        if (vid_d.hsync_start) vs_hss++;
      end
      @(posedge clk); #1;
    end
    check("line_hsync_cycles", hs_cnt, 32);
    check("line_hss_count", hss_cnt, 1);
    check("line_hss_x", hss_x, -72);
    check("line_de_cycles", de_cnt, 0);
    check("vs_cycles", vs_cnt, 1200);
    check("vs_first_x", vs_fx, -80);
    check("vs_first_y", vs_fy, -8);
    check("vs_last_x", vs_lx, 319);
    check("vs_last_y", vs_ly, -6);
    check("vs_hss_pulses", vs_hss, 3);
    repeat (20180) @(posedge clk);
    #1;
    check("mid_x", int'($signed(vid_d.x)), 100);
    check("mid_y", int'($signed(vid_d.y)), 50);
    check("mid_de", int'(vid_d.de), 1);
    #1 rst_d = 1'b1;
    #1;
    check("async_x", int'($signed(vid_d.x)), 319);
    check("async_y", int'($signed(vid_d.y)), 239);
    check("async_de", int'(vid_d.de), 0);
    check("async_hsync", int'(vid_d.hsync), 0);
    check("async_vsync", int'(vid_d.vsync), 0);
    check("async_fc", int'(vid_d.frame_count), 0);
    @(negedge clk);
    rst_d = 1'b0;
    @(posedge clk); #1;
    check("restart_x", int'($signed(vid_d.x)), -80);
    check("restart_y", int'($signed(vid_d.y)), -10);
    check("restart_fs", int'(vid_d.frame_start), 1);
    @(negedge clk);
    check("small_done", int'(done_s), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int de_s, vs_s, fs_n, last_fs, prev_fc;
    bit wrap_pend;
    de_s = 0; vs_s = 0; fs_n = 0; last_fs = 0; prev_fc = 0; wrap_pend = 1'b0;
    wait (rst_s == 1'b1);
    wait (rst_s == 1'b0);
    @(posedge clk); #1;
    check("s_first_x", int'($signed(vid_s.x)), -14);
    check("s_first_y", int'($signed(vid_s.y)), -5);
    check("s_first_hsync", int'(vid_s.hsync), 1);
    check("s_first_vsync", int'(vid_s.vsync), 1);
`ifdef DISPLAY_TIMING_FRAME_COUNT_EN
    check("s_first_fc", int'(vid_s.frame_count), 1);
`else
    check("s_first_fc", int'(vid_s.frame_count), 0);
`endif
    for (int i = 0; i < 990; i++) begin
      if (i < 330) begin
        if (vid_s.de) de_s++;
        if (!vid_s.vsync) vs_s++;
      end
      if (wrap_pend) begin
        check("s_wrap_x", int'($signed(vid_s.x)), -14);
        check("s_wrap_y", int'($signed(vid_s.y)), -5);
        check("s_wrap_fs", int'(vid_s.frame_start), 1);
`ifdef DISPLAY_TIMING_FRAME_COUNT_EN
        check("s_wrap_fc", int'(vid_s.frame_count), (prev_fc + 1) & 32'hFFFF);
`else
        check("s_wrap_fc", int'(vid_s.frame_count), 0);
`endif
        wrap_pend = 1'b0;
      end
      if (vid_s.frame_start) begin
        if (fs_n > 0) check("s_fs_period", i - last_fs, 330);
        last_fs = i;
        fs_n++;
      end
      if (int'($signed(vid_s.x)) == 15 && int'($signed(vid_s.y)) == 5) begin
        wrap_pend = 1'b1;
        prev_fc = int'(vid_s.frame_count);
      end
      @(posedge clk); #1;
    end
    check("s_de_cycles", de_s, 96);
    check("s_vs_cycles", vs_s, 60);
    check("s_fs_count", fs_n, 3);
    done_s = 1'b1;
  end

endmodule

`default_nettype wire
